// File: rtl/hazard_scoreboard_if.sv
// Signal bundle between the ID/EX pipeline control and the load-use hazard scoreboard.
// The master side drives pipeline status; the slave side (the scoreboard) returns stall controls.
interface hazard_scoreboard_if #(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
);
    logic [ADDR_W-1:0] RS1addr_i;
    logic [ADDR_W-1:0] RS2addr_i;
    logic              RS1use_i;
    logic              RS2use_i;
    logic              MemRead_i;
    logic [ADDR_W-1:0] RDaddr_i;
    logic              EXvalid_i;
    logic              MemStall_i;
    logic              Flush_i;
    logic              PCWrite_o;
    logic              Stall_o;
    logic              NoOp_o;
    logic              Overflow_o;
    logic [CNT_W-1:0]  StallCnt_o;

    modport master (
        output RS1addr_i, RS2addr_i, RS1use_i, RS2use_i, MemRead_i, RDaddr_i,
               EXvalid_i, MemStall_i, Flush_i,
        input  PCWrite_o, Stall_o, NoOp_o, Overflow_o, StallCnt_o
    );

    modport slave (
        input  RS1addr_i, RS2addr_i, RS1use_i, RS2use_i, MemRead_i, RDaddr_i,
               EXvalid_i, MemStall_i, Flush_i,
        output PCWrite_o, Stall_o, NoOp_o, Overflow_o, StallCnt_o
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Multi-cycle load-use hazard detector: tracks in-flight loads in a small countdown
// scoreboard and stalls the ID stage while any source register is still pending.
module hazard_scoreboard #(
    parameter int ADDR_W   = 5,
    parameter int LOAD_LAT = 3,
    parameter int DEPTH    = 4,
    parameter int CNT_W    = 16
) (
    input logic                clk_i,
    input logic                rst_i,
    hazard_scoreboard_if.slave bus
);
    localparam logic [3:0]       INIT_CNT = 4'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             load_in_ex;
    logic             alloc_req;
    logic             alloc_ok;
    logic [DEPTH-1:0] alloc_sel;
    logic [DEPTH-1:0] entry_valid;
    logic [DEPTH-1:0] rs1_sb_hit;
    logic [DEPTH-1:0] rs2_sb_hit;
    logic             rs1_match;
    logic             rs2_match;
    logic             hazard;
    logic             overflow_q;
    logic             overflow_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    assign load_in_ex = bus.EXvalid_i & bus.MemRead_i;
    assign alloc_req  = (LOAD_LAT > 1) && load_in_ex && (bus.RDaddr_i != '0) && !bus.MemStall_i;

    // Lowest free entry wins; occupancy is taken before this cycle's frees.
    always_comb begin
        alloc_sel = '0;
        alloc_ok  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (alloc_req && !alloc_ok && !entry_valid[i]) begin
                alloc_sel[i] = 1'b1;
                alloc_ok     = 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic              valid_q;
        logic              valid_d;
        logic [ADDR_W-1:0] rd_q;
        logic [ADDR_W-1:0] rd_d;
        logic [3:0]        cnt_q;
        logic [3:0]        cnt_d;

        always_comb begin
            valid_d = valid_q;
            rd_d    = rd_q;
            cnt_d   = cnt_q;
            if (!bus.MemStall_i) begin
                if (valid_q) begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        valid_d = 1'b0;
                    end
                end
                if (alloc_sel[gi]) begin
                    valid_d = 1'b1;
                    rd_d    = bus.RDaddr_i;
                    cnt_d   = INIT_CNT;
                end
            end
        end

        always_ff @(posedge clk_i) begin
            if (!rst_i) begin
                valid_q <= 1'b0;
                rd_q    <= '0;
                cnt_q   <= 4'd0;
            end else begin
                valid_q <= valid_d;
                rd_q    <= rd_d;
                cnt_q   <= cnt_d;
            end
        end

        assign entry_valid[gi] = valid_q;
        assign rs1_sb_hit[gi]  = valid_q && (rd_q == bus.RS1addr_i);
        assign rs2_sb_hit[gi]  = valid_q && (rd_q == bus.RS2addr_i);
    end

    // While reset is held the scoreboard is treated as empty; only the EX load can stall.
    assign rs1_match = bus.RS1use_i && (bus.RS1addr_i != '0) &&
                       ((load_in_ex && (bus.RDaddr_i == bus.RS1addr_i)) || (rst_i && (|rs1_sb_hit)));
    assign rs2_match = bus.RS2use_i && (bus.RS2addr_i != '0) &&
                       ((load_in_ex && (bus.RDaddr_i == bus.RS2addr_i)) || (rst_i && (|rs2_sb_hit)));
    assign hazard    = (rs1_match || rs2_match) && !bus.Flush_i;

    always_comb begin
        overflow_d  = overflow_q | (alloc_req & ~alloc_ok);
        stall_cnt_d = stall_cnt_q;
        if (hazard && !bus.MemStall_i && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            overflow_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            overflow_q  <= overflow_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.PCWrite_o  = ~hazard;
    assign bus.Stall_o    = hazard;
    assign bus.NoOp_o     = hazard;
    assign bus.Overflow_o = overflow_q;
    assign bus.StallCnt_o = stall_cnt_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: four configurations share one clock and reset,
// each scenario task drives its vectors and checks against hand-computed values.
module tb_hazard_scoreboard;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   exp3         = 0;

    localparam logic [2:0] GO   = 3'b100;
    localparam logic [2:0] HOLD = 3'b011;

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.ADDR_W(5), .CNT_W(16)) if3 ();
    hazard_scoreboard_if #(.ADDR_W(5), .CNT_W(16)) if1 ();
    hazard_scoreboard_if #(.ADDR_W(5), .CNT_W(16)) ifd ();
    hazard_scoreboard_if #(.ADDR_W(5), .CNT_W(2))  ifs ();

    hazard_scoreboard #(.ADDR_W(5), .LOAD_LAT(3), .DEPTH(4), .CNT_W(16)) u_l3 (
        .clk_i(clk), .rst_i(rst_n), .bus(if3));
    hazard_scoreboard #(.ADDR_W(5), .LOAD_LAT(1), .DEPTH(4), .CNT_W(16)) u_l1 (
        .clk_i(clk), .rst_i(rst_n), .bus(if1));
    hazard_scoreboard #(.ADDR_W(5), .LOAD_LAT(4), .DEPTH(1), .CNT_W(16)) u_d1 (
        .clk_i(clk), .rst_i(rst_n), .bus(ifd));
    hazard_scoreboard #(.ADDR_W(5), .LOAD_LAT(1), .DEPTH(1), .CNT_W(2)) u_sat (
        .clk_i(clk), .rst_i(rst_n), .bus(ifs));

    function automatic logic [2:0] ctl3();
        return {if3.PCWrite_o, if3.Stall_o, if3.NoOp_o};
    endfunction
    function automatic logic [2:0] ctl1();
        return {if1.PCWrite_o, if1.Stall_o, if1.NoOp_o};
    endfunction
    function automatic logic [2:0] ctld();
        return {ifd.PCWrite_o, ifd.Stall_o, ifd.NoOp_o};
    endfunction

    task automatic drive3(input logic ld, input logic [4:0] rd, input logic u1, input logic [4:0] a1,
                          input logic u2, input logic [4:0] a2, input logic ms, input logic fl);
        if3.EXvalid_i = ld; if3.MemRead_i = ld; if3.RDaddr_i = rd;
        if3.RS1use_i = u1; if3.RS1addr_i = a1; if3.RS2use_i = u2; if3.RS2addr_i = a2;
        if3.MemStall_i = ms; if3.Flush_i = fl;
    endtask
    task automatic drive1(input logic ev, input logic mr, input logic [4:0] rd, input logic u1,
                          input logic [4:0] a1, input logic u2, input logic [4:0] a2);
        if1.EXvalid_i = ev; if1.MemRead_i = mr; if1.RDaddr_i = rd;
        if1.RS1use_i = u1; if1.RS1addr_i = a1; if1.RS2use_i = u2; if1.RS2addr_i = a2;
        if1.MemStall_i = 1'b0; if1.Flush_i = 1'b0;
    endtask
    task automatic drived(input logic ld, input logic [4:0] rd, input logic u1, input logic [4:0] a1);
        ifd.EXvalid_i = ld; ifd.MemRead_i = ld; ifd.RDaddr_i = rd;
        ifd.RS1use_i = u1; ifd.RS1addr_i = a1; ifd.RS2use_i = 1'b0; ifd.RS2addr_i = 5'd0;
        ifd.MemStall_i = 1'b0; ifd.Flush_i = 1'b0;
    endtask
    task automatic drives(input logic ld, input logic [4:0] rd, input logic u1, input logic [4:0] a1);
        ifs.EXvalid_i = ld; ifs.MemRead_i = ld; ifs.RDaddr_i = rd;
        ifs.RS1use_i = u1; ifs.RS1addr_i = a1; ifs.RS2use_i = 1'b0; ifs.RS2addr_i = 5'd0;
        ifs.MemStall_i = 1'b0; ifs.Flush_i = 1'b0;
    endtask

    task automatic idle_all();
        drive3(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        drive1(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        drived(1'b0, 5'd0, 1'b0, 5'd0);
        drives(1'b0, 5'd0, 1'b0, 5'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        $display("[TB] t=%0t rst=%b l3=%b/%0d l1=%b/%0d d1=%b ovf=%b sat=%0d", $time, rst_n,
                 ctl3(), if3.StallCnt_o, ctl1(), if1.StallCnt_o, ctld(), ifd.Overflow_o, ifs.StallCnt_o);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_all();
        step();
        step();
        drive3(1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        tests_run++;
        if (ctl3() !== GO) begin tests_failed++; $display("FAIL reset_ctl: ctl=%b expected %b", ctl3(), GO); end
        tests_run++;
        if ({if3.Overflow_o, ifd.Overflow_o} !== 2'b00) begin
            tests_failed++; $display("FAIL reset_overflow: ovf=%b expected 00", {if3.Overflow_o, ifd.Overflow_o});
        end
        tests_run++;
        if (if3.StallCnt_o !== 16'd0) begin tests_failed++; $display("FAIL reset_cnt: cnt=%0d expected 0", if3.StallCnt_o); end
        drive3(1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        tests_run++;
        if (ctl3() !== HOLD) begin tests_failed++; $display("FAIL reset_ex_load: ctl=%b expected %b", ctl3(), HOLD); end
        idle_all();
        step();
        rst_n = 1'b1;
        step();
        exp3 = 0;
    endtask

    task automatic test_load_use();
        logic [2:0] exp_ctl;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) drive3(1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0);
            else        drive3(1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0);
            #1;
            exp_ctl = (i < 3) ? HOLD : GO;
            tests_run++;
            if (ctl3() !== exp_ctl) begin tests_failed++; $display("FAIL load_use[%0d]: ctl=%b expected %b", i, ctl3(), exp_ctl); end
            step();
        end
        exp3 += 3;
        tests_run++;
        if (if3.StallCnt_o !== 16'(exp3)) begin tests_failed++; $display("FAIL load_use_cnt: cnt=%0d expected %0d", if3.StallCnt_o, exp3); end
        idle_all();
    endtask

    task automatic test_memstall();
        logic [7:0] ms_v;
        logic [7:0] st_v;
        logic [2:0] exp_ctl;
        ms_v = 8'b0001_1110;
        st_v = 8'b0111_1111;
        for (int i = 0; i < 8; i++) begin
            drive3((i == 0), (i == 0) ? 5'd5 : 5'd0, 1'b1, 5'd5, 1'b0, 5'd0, ms_v[i], 1'b0);
            #1;
            exp_ctl = st_v[i] ? HOLD : GO;
            tests_run++;
            if (ctl3() !== exp_ctl) begin tests_failed++; $display("FAIL memstall[%0d]: ctl=%b expected %b", i, ctl3(), exp_ctl); end
            step();
        end
        exp3 += 3;
        tests_run++;
        if (if3.StallCnt_o !== 16'(exp3)) begin tests_failed++; $display("FAIL memstall_cnt: cnt=%0d expected %0d", if3.StallCnt_o, exp3); end
        idle_all();
    endtask

    task automatic test_flush();
        drive3(1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 1'b1);
        #1;
        tests_run++;
        if (ctl3() !== GO) begin tests_failed++; $display("FAIL flush_ex: ctl=%b expected %b", ctl3(), GO); end
        step();
        drive3(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0);
        #1;
        tests_run++;
        if (ctl3() !== HOLD) begin tests_failed++; $display("FAIL flush_entry_kept: ctl=%b expected %b", ctl3(), HOLD); end
        step();
        drive3(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 1'b1);
        #1;
        tests_run++;
        if (ctl3() !== GO) begin tests_failed++; $display("FAIL flush_sb: ctl=%b expected %b", ctl3(), GO); end
        drive3(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0);
        #1;
        tests_run++;
        if (ctl3() !== HOLD) begin tests_failed++; $display("FAIL flush_sb_release: ctl=%b expected %b", ctl3(), HOLD); end
        step();
        #1;
        tests_run++;
        if (ctl3() !== GO) begin tests_failed++; $display("FAIL flush_expire: ctl=%b expected %b", ctl3(), GO); end
        step();
        exp3 += 2;
        tests_run++;
        if (if3.StallCnt_o !== 16'(exp3)) begin tests_failed++; $display("FAIL flush_cnt: cnt=%0d expected %0d", if3.StallCnt_o, exp3); end
        idle_all();
    endtask

    task automatic test_back_to_back();
        drive3(1'b1, 5'd5, 1'b1, 5'd6, 1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        tests_run++;
        if (ctl3() !== GO) begin tests_failed++; $display("FAIL b2b_other_reg: ctl=%b expected %b", ctl3(), GO); end
        step();
        drive3(1'b1, 5'd7, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        tests_run++;
        if (ctl3() !== HOLD) begin tests_failed++; $display("FAIL b2b_first: ctl=%b expected %b", ctl3(), HOLD); end
        step();
        drive3(1'b0, 5'd0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        tests_run++;
        if (ctl3() !== HOLD) begin tests_failed++; $display("FAIL b2b_second: ctl=%b expected %b", ctl3(), HOLD); end
        step();
        drive3(1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        tests_run++;
        if (ctl3() !== GO) begin tests_failed++; $display("FAIL b2b_first_done: ctl=%b expected %b", ctl3(), GO); end
        drive3(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0, 1'b0);
        #1;
        tests_run++;
        if (ctl3() !== HOLD) begin tests_failed++; $display("FAIL b2b_second_rs2: ctl=%b expected %b", ctl3(), HOLD); end
        step();
        drive3(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd7, 1'b0, 1'b0);
        #1;
        tests_run++;
        if (ctl3() !== GO) begin tests_failed++; $display("FAIL b2b_x0_done: ctl=%b expected %b", ctl3(), GO); end
        step();
        exp3 += 3;
        tests_run++;
        if ({if3.Overflow_o, if3.StallCnt_o} !== {1'b0, 16'(exp3)}) begin
            tests_failed++; $display("FAIL b2b_cnt: ovf=%b cnt=%0d expected ovf=0 cnt=%0d", if3.Overflow_o, if3.StallCnt_o, exp3);
        end
        idle_all();
    endtask

    task automatic test_single_cycle();
        drive1(1'b1, 1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 5'd0);
        #1;
        tests_run++;
        if (ctl1() !== HOLD) begin tests_failed++; $display("FAIL lat1_use: ctl=%b expected %b", ctl1(), HOLD); end
        step();
        drive1(1'b0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 5'd0);
        #1;
        tests_run++;
        if (ctl1() !== GO) begin tests_failed++; $display("FAIL lat1_one_cycle: ctl=%b expected %b", ctl1(), GO); end
        drive1(1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0);
        #1;
        tests_run++;
        if (ctl1() !== GO) begin tests_failed++; $display("FAIL lat1_x0: ctl=%b expected %b", ctl1(), GO); end
        drive1(1'b1, 1'b1, 5'd5, 1'b0, 5'd5, 1'b0, 5'd0);
        #1;
        tests_run++;
        if (ctl1() !== GO) begin tests_failed++; $display("FAIL lat1_nouse: ctl=%b expected %b", ctl1(), GO); end
        drive1(1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 5'd5);
        #1;
        tests_run++;
        if (ctl1() !== GO) begin tests_failed++; $display("FAIL lat1_bubble: ctl=%b expected %b", ctl1(), GO); end
        drive1(1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 5'd5);
        #1;
        tests_run++;
        if (ctl1() !== HOLD) begin tests_failed++; $display("FAIL lat1_rs2: ctl=%b expected %b", ctl1(), HOLD); end
        step();
        drive1(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5);
        #1;
        tests_run++;
        if ({ctl1(), if1.StallCnt_o} !== {GO, 16'd2}) begin
            tests_failed++; $display("FAIL lat1_cnt: ctl=%b cnt=%0d expected %b cnt=2", ctl1(), if1.StallCnt_o, GO);
        end
        idle_all();
    endtask

    task automatic test_saturation();
        int exp_cnt;
        drives(1'b1, 5'd5, 1'b1, 5'd5);
        for (int i = 0; i < 5; i++) begin
            step();
            exp_cnt = (i < 3) ? i + 1 : 3;
            tests_run++;
            if (ifs.StallCnt_o !== 2'(exp_cnt)) begin tests_failed++; $display("FAIL sat[%0d]: cnt=%0d expected %0d", i, ifs.StallCnt_o, exp_cnt); end
        end
        idle_all();
    endtask

    task automatic test_overflow();
        drived(1'b1, 5'd5, 1'b0, 5'd0);
        step();
        drived(1'b1, 5'd6, 1'b0, 5'd0);
        #1;
        tests_run++;
        if (ifd.Overflow_o !== 1'b0) begin tests_failed++; $display("FAIL ovf_early: ovf=%b expected 0", ifd.Overflow_o); end
        step();
        drived(1'b0, 5'd0, 1'b1, 5'd6);
        #1;
        tests_run++;
        if ({ifd.Overflow_o, ctld()} !== {1'b1, GO}) begin
            tests_failed++; $display("FAIL ovf_dropped: ovf=%b ctl=%b expected ovf=1 ctl=%b", ifd.Overflow_o, ctld(), GO);
        end
        drived(1'b0, 5'd0, 1'b1, 5'd5);
        #1;
        tests_run++;
        if (ctld() !== HOLD) begin tests_failed++; $display("FAIL ovf_first_kept: ctl=%b expected %b", ctld(), HOLD); end
        idle_all();
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if (ifd.Overflow_o !== 1'b1) begin tests_failed++; $display("FAIL ovf_sticky[%0d]: ovf=%b expected 1", i, ifd.Overflow_o); end
        end
    endtask

    task automatic test_reset_mid();
        drive3(1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        tests_run++;
        if (ctl3() !== HOLD) begin tests_failed++; $display("FAIL rstmid_load: ctl=%b expected %b", ctl3(), HOLD); end
        step();
        rst_n = 1'b0;
        drive3(1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        tests_run++;
        if (ctl3() !== GO) begin tests_failed++; $display("FAIL rstmid_masked: ctl=%b expected %b", ctl3(), GO); end
        step();
        rst_n = 1'b1;
        #1;
        tests_run++;
        if ({ctl3(), if3.StallCnt_o, ifd.Overflow_o} !== {GO, 16'd0, 1'b0}) begin
            tests_failed++; $display("FAIL rstmid_after: ctl=%b cnt=%0d ovf=%b expected %b cnt=0 ovf=0", ctl3(), if3.StallCnt_o, ifd.Overflow_o, GO);
        end
        step();
        exp3 = 0;
        idle_all();
    endtask

    task automatic test_alloc_free_same_cycle();
        drived(1'b1, 5'd3, 1'b0, 5'd0);
        step();
        drived(1'b0, 5'd0, 1'b0, 5'd0);
        step();
        step();
        drived(1'b1, 5'd4, 1'b1, 5'd3);
        #1;
        tests_run++;
        if (ctld() !== HOLD) begin tests_failed++; $display("FAIL afs_last_cycle: ctl=%b expected %b", ctld(), HOLD); end
        step();
        drived(1'b0, 5'd0, 1'b1, 5'd4);
        #1;
        tests_run++;
        if ({ifd.Overflow_o, ctld()} !== {1'b1, GO}) begin
            tests_failed++; $display("FAIL afs_no_reuse: ovf=%b ctl=%b expected ovf=1 ctl=%b", ifd.Overflow_o, ctld(), GO);
        end
        drived(1'b0, 5'd0, 1'b1, 5'd3);
        #1;
        tests_run++;
        if (ctld() !== GO) begin tests_failed++; $display("FAIL afs_freed: ctl=%b expected %b", ctld(), GO); end
        idle_all();
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_all();
        test_reset();
        test_load_use();
        test_memstall();
        test_flush();
        test_back_to_back();
        test_single_cycle();
        test_saturation();
        test_overflow();
        test_reset_mid();
        test_alloc_free_same_cycle();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
